// File: rtl/chronospatial_core.sv
// Runtime-loadable 3-bit chronospatial machine: program and register A are
// shifted in over a write port, executed by a start/halt/error FSM.
module chronospatial_core #(
    parameter int unsigned REG_W      = 48,
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_clr,
    input  logic             prog_wr_en,
    input  logic [2:0]       prog_wr_data,
    input  logic             a_wr_en,
    input  logic [2:0]       a_wr_data,
    input  logic             start,
    output logic [2:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] out_count
);
    localparam int unsigned AW  = $clog2(PROG_DEPTH);
    localparam int unsigned IPW = AW + 1;
    localparam logic [REG_W-1:0] SHIFT_LIM = REG_W'(REG_W);
    localparam logic [IPW-1:0]   DEPTH_V   = IPW'(PROG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_OUT_WAIT, S_HALT, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [REG_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [IPW-1:0]   ip_q, ip_d, prog_len_q, prog_len_d;
    logic [2:0]       opc_q, opc_d, opr_q, opr_d, out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       prog_q [PROG_DEPTH];

    logic             prog_we;
    logic             load_ok;
    logic             bad_combo;
    logic [IPW:0]     ip_p1;
    logic [REG_W-1:0] combo;
    logic [REG_W-1:0] shifted;

    assign load_ok = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERROR);
    assign ip_p1   = {1'b0, ip_q} + (IPW+1)'(1);

    always_comb begin
        unique case (opr_q)
            3'd4:    combo = a_q;
            3'd5:    combo = b_q;
            3'd6:    combo = c_q;
            default: combo = REG_W'(opr_q);
        endcase
    end

    // Full-width shift amount; anything at or beyond the register width clears.
    assign shifted = (combo >= SHIFT_LIM) ? '0 : (a_q >> combo);

    // bxl, jnz and bxc take a literal or no operand, so operand 7 is legal there.
    assign bad_combo = (opr_q == 3'd7) && !(opc_q == 3'd1 || opc_q == 3'd3 || opc_q == 3'd4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            ip_q       <= '0;
            prog_len_q <= '0;
            opc_q      <= '0;
            opr_q      <= '0;
            out_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            ip_q       <= ip_d;
            prog_len_q <= prog_len_d;
            opc_q      <= opc_d;
            opr_q      <= opr_d;
            out_q      <= out_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && prog_we) begin
            prog_q[prog_len_q[AW-1:0]] <= prog_wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        ip_d       = ip_q;
        prog_len_d = prog_len_q;
        opc_d      = opc_q;
        opr_d      = opr_q;
        out_d      = out_q;
        cnt_d      = cnt_q;
        prog_we    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (ip_p1 >= {1'b0, prog_len_q}) begin
                    state_d = S_HALT;
                end else begin
                    opc_d   = prog_q[ip_q[AW-1:0]];
                    opr_d   = prog_q[ip_p1[AW-1:0]];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bad_combo) begin
                    state_d = S_ERROR;
                end else begin
                    ip_d    = ip_q + IPW'(2);
                    state_d = S_FETCH;
                    unique case (opc_q)
                        3'd0: a_d = shifted;
                        3'd1: b_d = b_q ^ REG_W'(opr_q);
                        3'd2: b_d = REG_W'(combo[2:0]);
                        3'd3: if (a_q != '0) ip_d = IPW'(opr_q);
                        3'd4: b_d = b_q ^ c_q;
                        3'd5: begin
                            out_d   = combo[2:0];
                            state_d = S_OUT_WAIT;
                        end
                        3'd6: b_d = shifted;
                        3'd7: c_d = shifted;
                        default: ;
                    endcase
                end
            end
            S_OUT_WAIT: begin
                if (out_ready) begin
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                // Loads land before start so a same-cycle start sees the new A.
                if (load_ok) begin
                    if (prog_clr) begin
                        prog_len_d = '0;
                    end else if (prog_wr_en && (prog_len_q != DEPTH_V)) begin
                        prog_we    = 1'b1;
                        prog_len_d = prog_len_q + IPW'(1);
                    end
                    if (a_wr_en) a_d = {a_q[REG_W-4:0], a_wr_data};
                    if (start) begin
                        ip_d    = '0;
                        b_d     = '0;
                        c_d     = '0;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_OUT_WAIT);
        halted    = (state_q == S_HALT);
        error     = (state_q == S_ERROR);
        out_valid = (state_q == S_OUT_WAIT);
        out_data  = out_q;
        out_count = cnt_q;
    end

endmodule

// File: tb/tb_chronospatial_core.sv
// Bench for chronospatial_core: directed scenarios plus random programs,
// all checked against an instruction-level reference interpreter.
module tb_chronospatial_core;
    localparam int unsigned REG_W      = 48;
    localparam int unsigned PROG_DEPTH = 16;
    localparam int unsigned CNT_W      = 8;
    localparam longint unsigned MASK   = (64'd1 << REG_W) - 64'd1;

    logic             clk = 1'b0;
    logic             rst_n, prog_clr, prog_wr_en, a_wr_en, start, out_ready;
    logic [2:0]       prog_wr_data, a_wr_data, out_data;
    logic             out_valid, busy, halted, error;
    logic [CNT_W-1:0] out_count;

    always #5 clk = ~clk;

    chronospatial_core #(
        .REG_W      (REG_W),
        .PROG_DEPTH (PROG_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_clr     (prog_clr),
        .prog_wr_en   (prog_wr_en),
        .prog_wr_data (prog_wr_data),
        .a_wr_en      (a_wr_en),
        .a_wr_data    (a_wr_data),
        .start        (start),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .halted       (halted),
        .error        (error),
        .out_count    (out_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference state
    longint unsigned m_a;
    longint unsigned exp_a, exp_b, exp_c;
    int              exp_q[$];
    bit              exp_err;
    int              exp_steps;
    int              prog[$];

    function automatic longint unsigned shr(input longint unsigned a, input longint unsigned n);
        if (n >= REG_W) return 0;
        return a / (64'd1 << n);
    endfunction

    // Interpreter over the stored program (capped at PROG_DEPTH words).
    task automatic model(output bit ok);
        longint unsigned a, b, c, cb;
        int ip, len, op, arg;
        a = m_a; b = 0; c = 0; ip = 0;
        len = (prog.size() > PROG_DEPTH) ? PROG_DEPTH : prog.size();
        exp_q.delete(); exp_err = 0; exp_steps = 0; ok = 0;
        while (exp_steps < 150) begin
            if (ip + 1 >= len) begin ok = 1; break; end
            op = prog[ip]; arg = prog[ip+1];
            exp_steps++;
            if (arg < 4)       cb = arg;
            else if (arg == 4) cb = a;
            else if (arg == 5) cb = b;
            else               cb = c;
            if (arg == 7 && op != 1 && op != 3 && op != 4) begin
                exp_err = 1; ok = 1; break;
            end
            if (op == 3 && a != 0) begin
                ip = arg;
            end else begin
                case (op)
                    0: a = shr(a, cb);
                    1: b = b ^ arg;
                    2: b = cb % 8;
                    4: b = b ^ c;
                    5: exp_q.push_back(int'(cb % 8));
                    6: b = shr(a, cb);
                    7: c = shr(a, cb);
                    default: ;
                endcase
                ip += 2;
            end
        end
        exp_a = a; exp_b = b; exp_c = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; prog_clr = 0; prog_wr_en = 0; a_wr_en = 0; start = 0; out_ready = 0;
        prog_wr_data = 0; a_wr_data = 0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_count", out_count, 0);
        check("rst_data", out_data, 0);
        check("rst_a", dut.a_q, 0);
        check("rst_len", dut.prog_len_q, 0);
        rst_n = 1'b1;
        m_a = 0;
    endtask

    task automatic load_a(input int d);
        a_wr_en = 1; a_wr_data = 3'(d);
        @(negedge clk);
        a_wr_en = 0;
        m_a = ((m_a << 3) | longint'(d)) & MASK;
    endtask

    task automatic load_prog();
        prog_clr = 1;
        @(negedge clk);
        prog_clr = 0;
        foreach (prog[i]) begin
            prog_wr_en = 1; prog_wr_data = 3'(prog[i]);
            @(negedge clk);
        end
        prog_wr_en = 0;
    endtask

    task automatic run_prog(input string nm, input int stall, input bit rnd, input bit disturb);
        int idx = 0, w = 0, busy_cyc = 0, nexp, len0;
        bit done = 0, ok;
        model(ok);
        nexp = exp_q.size();
        len0 = int'(dut.prog_len_q);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            if (!busy) begin
                done = 1;
            end else begin
                busy_cyc++;
                if (disturb) begin
                    prog_wr_en = 1; prog_wr_data = 3'($urandom);
                    a_wr_en = 1; a_wr_data = 3'($urandom);
                    prog_clr = 1'($urandom);
                end
                if (out_valid) begin
                    if (idx < nexp) check({nm, "_out"}, out_data, exp_q[idx]);
                    else            check({nm, "_extra_out"}, 1, 0);
                    out_ready = rnd ? 1'($urandom) : (w >= stall);
                    if (out_ready) begin idx++; w = 0; end
                    else w++;
                end else begin
                    out_ready = rnd ? 1'($urandom) : 1'b0;
                end
                @(negedge clk);
            end
        end
        out_ready = 0; prog_wr_en = 0; a_wr_en = 0; prog_clr = 0;
        check({nm, "_finished"}, done, 1);
        check({nm, "_nout"}, idx, nexp);
        check({nm, "_halted"}, halted, !exp_err);
        check({nm, "_error"}, error, exp_err);
        check({nm, "_count"}, out_count, (nexp > 255) ? 255 : nexp);
        check({nm, "_a"}, dut.a_q, exp_a);
        check({nm, "_b"}, dut.b_q, exp_b);
        check({nm, "_c"}, dut.c_q, exp_c);
        if (!rnd)
            check({nm, "_cycles"}, busy_cyc, 2*exp_steps + nexp*(stall+1) + (exp_err ? 0 : 1));
        if (disturb) check({nm, "_len_kept"}, dut.prog_len_q, len0);
        m_a = exp_a;
    endtask

    task automatic setup_729();
        do_reset();
        load_a(1); load_a(3); load_a(3); load_a(1);
        prog = '{0, 1, 5, 4, 3, 0};
        load_prog();
    endtask

    initial begin
        bit ok, found;
        do_reset();

        setup_729();
        check("a729", dut.a_q, 729);
        run_prog("t729", 0, 0, 0);

        do_reset();
        load_a(3); load_a(4); load_a(5); load_a(3); load_a(0); load_a(0);
        check("a117440", dut.a_q, 117440);
        prog = '{0, 3, 5, 4, 3, 0};
        load_prog();
        run_prog("quine", 0, 0, 0);

        setup_729();
        run_prog("stall", 5, 0, 0);

        do_reset();
        load_a(6); load_a(0);
        prog = '{0, 4, 5, 4};
        load_prog();
        run_prog("shift48", 0, 0, 0);

        do_reset();
        prog = '{2, 7};
        load_prog();
        run_prog("err27", 0, 0, 0);
        prog = '{1, 7, 5, 5};
        load_prog();
        run_prog("bxl7", 0, 0, 0);

        do_reset();
        load_a(5);
        prog = '{5, 4, 5};
        load_prog();
        run_prog("odd", 0, 0, 0);

        do_reset();
        prog.delete();
        for (int i = 0; i < PROG_DEPTH + 2; i++) prog.push_back($urandom_range(0, 7));
        load_prog();
        check("len_sat", dut.prog_len_q, PROG_DEPTH);
        check("no_wrap", dut.prog_q[0], prog[0]);
        check("last_word", dut.prog_q[PROG_DEPTH-1], prog[PROG_DEPTH-1]);

        setup_729();
        run_prog("busywr", 2, 0, 1);

        setup_729();
        start = 1;
        @(negedge clk);
        start = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid) found = 1;
            else @(negedge clk);
        end
        check("midrst_reached", found, 1);
        rst_n = 0;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_halted", halted, 0);
        check("midrst_error", error, 0);
        check("midrst_count", out_count, 0);
        rst_n = 1;
        m_a = 0;

        for (int t = 0; t < 25; t++) begin
            for (int d = 0; d < 16; d++) load_a($urandom_range(0, 7));
            ok = 0;
            for (int tries = 0; tries < 100 && !ok; tries++) begin
                prog.delete();
                for (int i = $urandom_range(0, PROG_DEPTH); i > 0; i--)
                    prog.push_back($urandom_range(0, 7));
                model(ok);
            end
            if (ok) begin
                load_prog();
                run_prog("rand", 0, (t % 2) == 1, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
